winograd_post_transform_2d_pipe: RTL

//  Streaming 2-D Winograd F(4x4,3x3) output transform: Y = A^T * M * A, M a 6x6 tile of

---
 rtl/winograd_post_transform_2d_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/winograd_post_transform_2d_pipe.sv
// Winograd F(4x4,3x3) output transform Y = A^T*M*A: rows of M stream in, rows of Y stream out.
// Row transform on input, column transform + rounding/saturation in two cycles, then a 4-beat drain.
module winograd_post_transform_2d_pipe #(
  parameter int IN_WIDTH  = 40,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 0,
  parameter int SATURATE  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6*IN_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*OUT_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   out_sat,
  output logic                   frame_err
);
  localparam int UW = IN_WIDTH + 5;
  localparam int YW = IN_WIDTH + 10;
  localparam logic signed [YW:0] RND  =
    (SHIFT > 0) ? ((YW+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [YW:0] MAXV = (YW+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [YW:0] MINV = ~MAXV;

  typedef enum logic [1:0] {FILL, CALC, POST, DRAIN} state_t;

  state_t                  state;
  logic [2:0]              row_cnt;
  logic [1:0]              out_cnt;
  logic                    accept;
  logic signed [IN_WIDTH-1:0] m [6];
  logic signed [UW-1:0]    ubuf [6][4];
  logic signed [YW-1:0]    yw [4][4];
  logic [OUT_WIDTH:0]      pr [4][4];
  logic [3:0]              ps;
  logic [OUT_WIDTH-1:0]    yreg [4][4];
  logic [3:0]              satreg;

  // One row of A^T dotted with a 6-vector; x2/x4/x8 taps are shifts.
  function automatic logic signed [YW-1:0] at_dot(
    input logic [1:0] j,
    input logic signed [YW-1:0] v0, v1, v2, v3, v4, v5);
    case (j)
      2'd0:    return v0 + v1 + v2 + v3 + v4;
      2'd1:    return v1 - v2 + (v3 <<< 1) - (v4 <<< 1);
      2'd2:    return v1 + v2 + (v3 <<< 2) + (v4 <<< 2);
      default: return v1 - v2 + (v3 <<< 3) - (v4 <<< 3) + v5;
    endcase
  endfunction

  // Returns {clamped, value}: round half toward +inf, shift, then clamp or truncate.
  function automatic logic [OUT_WIDTH:0] post_scale(input logic signed [YW-1:0] x);
    logic signed [YW:0]   t;
    logic [OUT_WIDTH-1:0] v;
    logic                 sat;
    t   = (YW+1)'(x) + RND;
    t   = t >>> SHIFT;
    v   = t[OUT_WIDTH-1:0];
    sat = 1'b0;
    if (SATURATE != 0) begin
      if (t > MAXV) begin
        v   = MAXV[OUT_WIDTH-1:0];
        sat = 1'b1;
      end else if (t < MINV) begin
        v   = MINV[OUT_WIDTH-1:0];
        sat = 1'b1;
      end
    end
    return {sat, v};
  endfunction

  assign in_ready  = (state == FILL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && (out_cnt == 2'd3);
  assign out_sat   = out_valid && satreg[out_cnt];

  always_comb begin
    for (int k = 0; k < 6; k++) m[k] = in_data[k*IN_WIDTH +: IN_WIDTH];
  end

  always_comb begin
    out_data = '0;
    if (out_valid)
      for (int j = 0; j < 4; j++) out_data[j*OUT_WIDTH +: OUT_WIDTH] = yreg[out_cnt][j];
  end

  always_comb begin
    ps = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) begin
        pr[r][j] = post_scale(yw[r][j]);
        ps[r]    = ps[r] | pr[r][j][OUT_WIDTH];
      end
  end

  // Datapath storage carries no reset; the FSM gates everything visible.
  always_ff @(posedge clk) begin
    if (accept)
      for (int j = 0; j < 4; j++)
        ubuf[row_cnt][j] <= UW'(at_dot(2'(j), YW'(m[0]), YW'(m[1]), YW'(m[2]),
                                       YW'(m[3]), YW'(m[4]), YW'(m[5])));
    if (state == CALC)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          yw[r][j] <= at_dot(2'(r), YW'(ubuf[0][j]), YW'(ubuf[1][j]), YW'(ubuf[2][j]),
                             YW'(ubuf[3][j]), YW'(ubuf[4][j]), YW'(ubuf[5][j]));
    if (state == POST) begin
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++) yreg[r][j] <= pr[r][j][OUT_WIDTH-1:0];
      satreg <= ps;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      row_cnt   <= '0;
      out_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: if (accept) begin
          frame_err <= (row_cnt == 3'd5) ? !in_last : in_last;
          if (row_cnt == 3'd5) begin
            row_cnt <= '0;
            state   <= CALC;
          end else if (in_last) begin
            // early in_last: drop the partial tile and resynchronise
            row_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + 3'd1;
          end
        end
        CALC: state <= POST;
        POST: begin
          out_cnt <= '0;
          state   <= DRAIN;
        end
        default: if (out_ready) begin
          out_cnt <= out_cnt + 2'd1;
          if (out_cnt == 2'd3) state <= FILL;
        end
      endcase
    end
  end
endmodule
